// File: rtl/lsu_mem_master.sv
// RV64 load/store initiator: one request in flight, 8-byte-aligned byte-enabled memory beats.
// `LSU_SPLIT_MISALIGNED_EN builds the two-beat path for accesses crossing an 8-byte boundary.
module lsu_mem_master #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_store_i,
  input  logic [2:0]              req_funct3_i,
  input  logic [DATA_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  output logic                    resp_valid_o,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic                    resp_fault_o,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic [DATA_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [7:0]              mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5,
    ST_FAULT = 3'd6
  } state_e;

  state_e      state_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [63:0] resp_rdata_q;
  logic        resp_fault_q;
  logic        mem_req_valid_q;
  logic [63:0] mem_addr_q;
  logic        mem_we_q;
  logic [7:0]  mem_be_q;
  logic [63:0] mem_wdata_q;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [2:0]  off_q;

  logic [7:0]  size_mask_s;
  logic        illegal_s;
  logic [7:0]  be0_s;
  logic [63:0] wd0_s;
  logic [63:0] ld_lo_s;
  logic [63:0] ld_hi_s;
  logic [63:0] ld_word_s;
  logic [63:0] ld_resp_s;

  function automatic logic [63:0] load_ext(input logic [2:0] f3, input logic [63:0] r);
    logic [63:0] v;
    case (f3)
      3'b000:  v = {{56{r[7]}}, r[7:0]};
      3'b001:  v = {{48{r[15]}}, r[15:0]};
      3'b010:  v = {{32{r[31]}}, r[31:0]};
      3'b011:  v = r;
      3'b100:  v = {56'd0, r[7:0]};
      3'b101:  v = {48'd0, r[15:0]};
      3'b110:  v = {32'd0, r[31:0]};
      default: v = 64'd0;
    endcase
    return v;
  endfunction

  // Byte mask of the access size, before lane positioning
  always_comb begin
    case (req_funct3_i[1:0])
      2'd0:    size_mask_s = 8'h01;
      2'd1:    size_mask_s = 8'h03;
      2'd2:    size_mask_s = 8'h0F;
      2'd3:    size_mask_s = 8'hFF;
      default: size_mask_s = 8'h00;
    endcase
  end

  // Request legality; without the split path any non-natural alignment faults
  always_comb begin
    if (req_store_i) begin
      illegal_s = req_funct3_i[2];
    end else begin
      illegal_s = (req_funct3_i == 3'b111);
    end
`ifndef LSU_SPLIT_MISALIGNED_EN
    case (req_funct3_i[1:0])
      2'd0:    illegal_s = illegal_s;
      2'd1:    illegal_s = illegal_s | req_addr_i[0];
      2'd2:    illegal_s = illegal_s | (|req_addr_i[1:0]);
      2'd3:    illegal_s = illegal_s | (|req_addr_i[2:0]);
      default: illegal_s = 1'b1;
    endcase
`endif
  end

`ifdef LSU_SPLIT_MISALIGNED_EN
  logic [14:0] mask15_s;
  logic [127:0] wd128_s;
  logic [6:0]  be1_q;
  logic [63:0] wdata1_q;
  logic [63:0] addr1_q;
  logic [63:0] rdata0_q;

  assign mask15_s = {7'd0, size_mask_s} << req_addr_i[2:0];
  assign wd128_s  = {64'd0, req_wdata_i} << {req_addr_i[2:0], 3'b000};
  assign be0_s    = mask15_s[7:0];
  assign wd0_s    = wd128_s[63:0];
`else
  assign be0_s = size_mask_s << req_addr_i[2:0];
  assign wd0_s = req_wdata_i << {req_addr_i[2:0], 3'b000};
`endif

  // Select the two read words that form the shifted load window
  always_comb begin
`ifdef LSU_SPLIT_MISALIGNED_EN
    if (state_q == ST_WAIT1) begin
      ld_lo_s = rdata0_q;
      ld_hi_s = mem_rdata_i;
    end else begin
      ld_lo_s = mem_rdata_i;
      ld_hi_s = 64'd0;
    end
`else
    ld_lo_s = mem_rdata_i;
    ld_hi_s = 64'd0;
`endif
  end

  assign ld_word_s = 64'({ld_hi_s, ld_lo_s} >> {off_q, 3'b000});
  assign ld_resp_s = store_q ? 64'd0 : load_ext(funct3_q, ld_word_s);

  // Transaction FSM; every output is a register updated on transitions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= 64'd0;
      resp_fault_q    <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= 64'd0;
      mem_we_q        <= 1'b0;
      mem_be_q        <= 8'd0;
      mem_wdata_q     <= 64'd0;
      store_q         <= 1'b0;
      funct3_q        <= 3'd0;
      off_q           <= 3'd0;
`ifdef LSU_SPLIT_MISALIGNED_EN
      be1_q           <= 7'd0;
      wdata1_q        <= 64'd0;
      addr1_q         <= 64'd0;
      rdata0_q        <= 64'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            req_ready_q <= 1'b0;
            store_q     <= req_store_i;
            funct3_q    <= req_funct3_i;
            off_q       <= req_addr_i[2:0];
            if (illegal_s) begin
              state_q      <= ST_FAULT;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_rdata_q <= 64'd0;
            end else begin
              state_q         <= ST_REQ0;
              mem_req_valid_q <= 1'b1;
              mem_addr_q      <= {req_addr_i[63:3], 3'b000};
              mem_we_q        <= req_store_i;
              mem_be_q        <= be0_s;
              mem_wdata_q     <= wd0_s;
`ifdef LSU_SPLIT_MISALIGNED_EN
              be1_q           <= mask15_s[14:8];
              wdata1_q        <= wd128_s[127:64];
              addr1_q         <= {req_addr_i[63:3] + 61'd1, 3'b000};
`endif
            end
          end
        end
        ST_REQ0: begin
          if (mem_req_ready_i) begin
            state_q         <= ST_WAIT0;
            mem_req_valid_q <= 1'b0;
          end
        end
        ST_WAIT0: begin
          if (mem_rvalid_i) begin
`ifdef LSU_SPLIT_MISALIGNED_EN
            if (be1_q != 7'd0) begin
              state_q         <= ST_REQ1;
              rdata0_q        <= mem_rdata_i;
              mem_req_valid_q <= 1'b1;
              mem_addr_q      <= addr1_q;
              mem_be_q        <= {1'b0, be1_q};
              mem_wdata_q     <= wdata1_q;
            end else begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= ld_resp_s;
            end
`else
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= ld_resp_s;
`endif
          end
        end
`ifdef LSU_SPLIT_MISALIGNED_EN
        ST_REQ1: begin
          if (mem_req_ready_i) begin
            state_q         <= ST_WAIT1;
            mem_req_valid_q <= 1'b0;
          end
        end
        ST_WAIT1: begin
          if (mem_rvalid_i) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= ld_resp_s;
          end
        end
`endif
        ST_RESP, ST_FAULT: begin
          state_q      <= ST_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_fault_q <= 1'b0;
          resp_rdata_q <= 64'd0;
        end
        default: begin
          state_q         <= ST_IDLE;
          req_ready_q     <= 1'b1;
          resp_valid_q    <= 1'b0;
          resp_fault_q    <= 1'b0;
          mem_req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o     = req_ready_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_rdata_o    = resp_rdata_q;
  assign resp_fault_o    = resp_fault_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_we_o        = mem_we_q;
  assign mem_be_o        = mem_be_q;
  assign mem_wdata_o     = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: memory responder model plus hand-computed expectations.
module tb_lsu_mem_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_store_i;
  logic [2:0]  req_funct3_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic        resp_valid_o;
  logic [63:0] resp_rdata_o;
  logic        resp_fault_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [63:0] mem_addr_o;
  logic        mem_we_o;
  logic [7:0]  mem_be_o;
  logic [63:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;

  lsu_mem_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_fault_o(resp_fault_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  int errors = 0;
  int checks = 0;

  logic [63:0] mem [32];
  logic [63:0] beat_addr [4];
  logic [7:0]  beat_be [4];
  logic        beat_we [4];
  logic [63:0] beat_wd [4];
  int          beat_n;
  logic        pending;
  logic [63:0] pend_data;
  logic        mem_hold;
  logic        late_pulse;

  int          lat;
  logic [63:0] r_rdata;
  logic        r_fault;
  logic [63:0] s_addr;
  logic [7:0]  s_be;
  logic [63:0] s_wd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Memory responder: acts 1 time unit after each falling edge so bench stimulus has settled
  initial begin
    pending      = 1'b0;
    pend_data    = 64'd0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 64'd0;
    forever begin
      @(negedge clk);
      #1;
      mem_rvalid_i = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
      end else if (pending && !mem_hold) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = pend_data;
        pending      = 1'b0;
      end else if (late_pulse) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hDEAD_BEEF_DEAD_BEEF;
        late_pulse   = 1'b0;
      end
      if (rst_n && mem_req_valid_o && mem_req_ready_i) begin
        if (beat_n < 4) begin
          beat_addr[beat_n] = mem_addr_o;
          beat_be[beat_n]   = mem_be_o;
          beat_we[beat_n]   = mem_we_o;
          beat_wd[beat_n]   = mem_wdata_o;
        end
        beat_n++;
        if (mem_we_o) begin
          for (int b = 0; b < 8; b++) begin
            if (mem_be_o[b]) mem[mem_addr_o[7:3]][b*8 +: 8] = mem_wdata_o[b*8 +: 8];
          end
          pend_data = 64'd0;
        end else begin
          pend_data = mem[mem_addr_o[7:3]];
        end
        pending = 1'b1;
      end
    end
  end

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd);
    beat_n       = 0;
    req_valid_i  = 1'b1;
    req_store_i  = st;
    req_funct3_i = f3;
    req_addr_i   = a;
    req_wdata_i  = wd;
    @(negedge clk);
    req_valid_i = 1'b0;
    lat = 1;
    while (!resp_valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("resp_seen", 64'(resp_valid_o), 64'd1);
    r_rdata = resp_rdata_o;
    r_fault = resp_fault_o;
    @(negedge clk);
    check("resp_pulse", 64'(resp_valid_o), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 64'd0;
    beat_n = 0; mem_hold = 1'b0; late_pulse = 1'b0;
    rst_n = 1'b0; req_valid_i = 1'b0; req_store_i = 1'b0; req_funct3_i = 3'd0;
    req_addr_i = 64'd0; req_wdata_i = 64'd0; mem_req_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(req_ready_o), 64'd1);
    check("rst_mvalid", 64'(mem_req_valid_o), 64'd0);
    check("rst_rvalid", 64'(resp_valid_o), 64'd0);
    check("rst_be", 64'(mem_be_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // SD aligned, zero-wait
    do_req(1'b1, 3'b011, 64'h10, 64'h1122_3344_5566_7788);
    check("sd_lat", 64'(lat), 64'd3);
    check("sd_beats", 64'(beat_n), 64'd1);
    check("sd_addr", beat_addr[0], 64'h10);
    check("sd_be", 64'(beat_be[0]), 64'hFF);
    check("sd_we", 64'(beat_we[0]), 64'd1);
    check("sd_wd", beat_wd[0], 64'h1122_3344_5566_7788);
    check("sd_rdata", r_rdata, 64'd0);
    check("sd_fault", 64'(r_fault), 64'd0);
    check("sd_mem", mem[2], 64'h1122_3344_5566_7788);

    // Load extension variants on one word
    mem[2] = 64'h0000_0000_8000_0000;
    do_req(1'b0, 3'b000, 64'h13, 64'd0);
    check("lb_lat", 64'(lat), 64'd3);
    check("lb_be", 64'(beat_be[0]), 64'h08);
    check("lb_we", 64'(beat_we[0]), 64'd0);
    check("lb_rdata", r_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    do_req(1'b0, 3'b100, 64'h13, 64'd0);
    check("lbu_rdata", r_rdata, 64'h0000_0000_0000_0080);
    do_req(1'b0, 3'b001, 64'h12, 64'd0);
    check("lh_be", 64'(beat_be[0]), 64'h0C);
    check("lh_rdata", r_rdata, 64'hFFFF_FFFF_FFFF_8000);
    do_req(1'b0, 3'b010, 64'h10, 64'd0);
    check("lw_rdata", r_rdata, 64'hFFFF_FFFF_8000_0000);
    do_req(1'b0, 3'b110, 64'h10, 64'd0);
    check("lwu_rdata", r_rdata, 64'h0000_0000_8000_0000);
    do_req(1'b0, 3'b011, 64'h10, 64'd0);
    check("ld_rdata", r_rdata, 64'h0000_0000_8000_0000);

    // SB lane placement then read back
    do_req(1'b1, 3'b000, 64'h1D, 64'h0000_0000_0000_00AB);
    check("sb_be", 64'(beat_be[0]), 64'h20);
    check("sb_wd", beat_wd[0], 64'h0000_AB00_0000_0000);
    check("sb_addr", beat_addr[0], 64'h18);
    do_req(1'b0, 3'b100, 64'h1D, 64'd0);
    check("sb_lbu", r_rdata, 64'h0000_0000_0000_00AB);

`ifdef LSU_SPLIT_MISALIGNED_EN
    mem[1] = 64'hBBAA_0000_0000_0000;
    mem[2] = 64'h0000_0000_0000_DDCC;
    do_req(1'b0, 3'b010, 64'h0E, 64'd0);
    check("split_lat", 64'(lat), 64'd5);
    check("split_beats", 64'(beat_n), 64'd2);
    check("split_a0", beat_addr[0], 64'h08);
    check("split_be0", 64'(beat_be[0]), 64'hC0);
    check("split_a1", beat_addr[1], 64'h10);
    check("split_be1", 64'(beat_be[1]), 64'h03);
    check("split_rdata", r_rdata, 64'hFFFF_FFFF_DDCC_BBAA);
    do_req(1'b1, 3'b010, 64'h0E, 64'h0000_0000_1122_3344);
    check("sw_split_wd0", beat_wd[0], 64'h3344_0000_0000_0000);
    check("sw_split_wd1", beat_wd[1], 64'h0000_0000_0000_1122);
    check("sw_split_be1", 64'(beat_be[1]), 64'h03);
`else
    do_req(1'b0, 3'b010, 64'h0E, 64'd0);
    check("mis_lat", 64'(lat), 64'd1);
    check("mis_fault", 64'(r_fault), 64'd1);
    check("mis_beats", 64'(beat_n), 64'd0);
    check("mis_rdata", r_rdata, 64'd0);
    do_req(1'b1, 3'b001, 64'h11, 64'h1234);
    check("mis_sh_fault", 64'(r_fault), 64'd1);
    check("mis_sh_beats", 64'(beat_n), 64'd0);
`endif
    do_req(1'b0, 3'b111, 64'h0, 64'd0);
    check("f3_111_lat", 64'(lat), 64'd1);
    check("f3_111_fault", 64'(r_fault), 64'd1);
    check("f3_111_beats", 64'(beat_n), 64'd0);
    do_req(1'b1, 3'b100, 64'h0, 64'd0);
    check("st_f3_fault", 64'(r_fault), 64'd1);
    check("st_f3_beats", 64'(beat_n), 64'd0);

    // Memory stall in REQ0 with a stray second request pulse
    mem_req_ready_i = 1'b0;
    beat_n = 0;
    req_valid_i = 1'b1; req_store_i = 1'b1; req_funct3_i = 3'b011;
    req_addr_i = 64'h20; req_wdata_i = 64'hCAFE_F00D_0000_1111;
    @(negedge clk);
    s_addr = mem_addr_o; s_be = mem_be_o; s_wd = mem_wdata_o;
    check("stall_mvalid", 64'(mem_req_valid_o), 64'd1);
    check("stall_addr0", s_addr, 64'h20);
    req_valid_i = 1'b1; req_store_i = 1'b0; req_funct3_i = 3'b011; req_addr_i = 64'h28;
    @(negedge clk);
    req_valid_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("stall_ready", 64'(req_ready_o), 64'd0);
      check("stall_addr", mem_addr_o, s_addr);
      check("stall_be", 64'(mem_be_o), 64'(s_be));
      check("stall_wd", mem_wdata_o, s_wd);
      check("stall_mvalid_hold", 64'(mem_req_valid_o), 64'd1);
      if (k == 0) @(negedge clk);
    end
    @(negedge clk);
    mem_req_ready_i = 1'b1;
    lat = 0;
    while (!resp_valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("stall_resp", 64'(resp_valid_o), 64'd1);
    check("stall_resp_ready", 64'(req_ready_o), 64'd0);
    @(negedge clk);
    check("stall_idle_ready", 64'(req_ready_o), 64'd1);
    check("stall_beats", 64'(beat_n), 64'd1);
    check("stall_beat_addr", beat_addr[0], 64'h20);
    check("stall_mem", mem[4], 64'hCAFE_F00D_0000_1111);

    // Reset in WAIT0 followed by a late rvalid
    mem[2] = 64'h0123_4567_89AB_CDEF;
    mem_hold = 1'b1;
    beat_n = 0;
    req_valid_i = 1'b1; req_store_i = 1'b0; req_funct3_i = 3'b011; req_addr_i = 64'h10;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    check("w0_mvalid", 64'(mem_req_valid_o), 64'd0);
    check("w0_ready", 64'(req_ready_o), 64'd0);
    rst_n = 1'b0;
    #1;
    check("arst_ready", 64'(req_ready_o), 64'd1);
    check("arst_mvalid", 64'(mem_req_valid_o), 64'd0);
    check("arst_rvalid", 64'(resp_valid_o), 64'd0);
    check("arst_addr", mem_addr_o, 64'd0);
    #1;
    late_pulse = 1'b1;
    mem_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("late_no_resp", 64'(resp_valid_o), 64'd0);
      check("late_ready", 64'(req_ready_o), 64'd1);
    end
    do_req(1'b0, 3'b011, 64'h10, 64'd0);
    check("post_rst_lat", 64'(lat), 64'd3);
    check("post_rst_rdata", r_rdata, 64'h0123_4567_89AB_CDEF);
    check("post_rst_fault", 64'(r_fault), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
